vip_projection_segmenter: RTL and testbench

Parametrised column-projection and segmentation stage for the plate-recognition binary video path. It accumulates a per-column count of `1` pixels inside a programmable row window, then scans the histogram once per frame. The scan yields up to `MAX_SEG` character segments as left/right column pairs. It sits after binarisation/erosion and feeds the character-crop and recognition logic, while passing the video stream through with a fixed delay.

---
 rtl/vip_proj_pkg.sv | 21 ++
 rtl/vip_proj_ram.sv | 31 +++
 rtl/vip_projection_segmenter.sv | 216 +++++++++++++++++++++
 tb/tb_vip_projection_segmenter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_proj_pkg.sv
// Shared types and helpers for the column-projection / segmentation stage.
//   state_t : projection FSM states
//   clog2   : elaboration-time width helper (ceil(log2(value)))
package vip_proj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int unsigned v = unsigned'(value - 1); v > 0; v = v >> 1)
      result++;
    return result;
  endfunction

endpackage

// File: rtl/vip_proj_ram.sv
// Column histogram store: simple dual-port RAM, DEPTH x DW.
//   clk     : clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rd_data : registered read data (1-cycle latency, old data on collision)
// No reset on the array so it maps onto block RAM.
module vip_proj_ram
  import vip_proj_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/vip_projection_segmenter.sv
// Column projection and character segmentation for the binary plate video.
//   clk, rst                 : pixel clock, async active-high reset
//   per_frame_*/per_img_Bit  : input binary video
//   post_frame_*/post_img_Bit: video delayed by exactly 2 clocks
//   row_start/row_end/thresh : row window and ink threshold, latched at frame start
//   seg_left/seg_right       : packed segment bounds, segment 0 in the LSBs
//   seg_num/seg_ovf          : valid segment count / too many segments found
//   result_valid/scan_abort  : result update pulse / scan cut short by new frame
module vip_projection_segmenter
  import vip_proj_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int MAX_SEG   = 8,
  parameter int MIN_W     = 2,
  localparam int X_W      = clog2(IMG_HDISP),
  localparam int Y_W      = clog2(IMG_VDISP),
  localparam int CNT_W    = clog2(IMG_VDISP + 1),
  localparam int N_W      = clog2(MAX_SEG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   per_frame_clken,
  input  logic                   per_img_Bit,
  output logic                   post_frame_vsync,
  output logic                   post_frame_href,
  output logic                   post_frame_clken,
  output logic                   post_img_Bit,
  input  logic [Y_W-1:0]         row_start,
  input  logic [Y_W-1:0]         row_end,
  input  logic [CNT_W-1:0]       thresh,
  output logic [MAX_SEG*X_W-1:0] seg_left,
  output logic [MAX_SEG*X_W-1:0] seg_right,
  output logic [N_W-1:0]         seg_num,
  output logic                   seg_ovf,
  output logic                   result_valid,
  output logic                   scan_abort
);

  localparam logic [X_W:0] MIN_WV = (X_W + 1)'(MIN_W);

  state_t state, nxt;
  logic [3:0] vid_d0, vid_d1;
  logic vsync_d, href_d, vsync_rise, href_fall;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt, win_lo, win_hi;
  logic [CNT_W-1:0] thr, rd_data, wr_data;
  logic in_window, wr_pend, wr_row0, wr_inc;
  logic [X_W-1:0] wr_addr, rd_addr;
  logic [X_W:0] scan_cnt;
  logic v1, v2, ink;
  logic [X_W-1:0] col1, col2;
  logic run_open;
  logic [X_W-1:0] run_left, run_right, cl_left, cl_right;
  logic [X_W:0] cl_width;
  logic close_run, keep_run, scan_entry;
  logic [MAX_SEG*X_W-1:0] sh_left, sh_right;
  logic [N_W-1:0] sh_num;
  logic sh_ovf;

  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = ~per_frame_href & href_d;
  assign in_window  = (y_cnt >= win_lo) && (y_cnt <= win_hi);
  assign {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} = vid_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_d0 <= '0; vid_d1 <= '0; vsync_d <= 1'b0; href_d <= 1'b0;
    end else begin
      vid_d0 <= {per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit};
      vid_d1 <= vid_d0;
      vsync_d <= per_frame_vsync;
      href_d <= per_frame_href;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = IDLE;
      ACCUM: if (href_fall && y_cnt == Y_W'(IMG_VDISP - 1)) nxt = SCAN;
      SCAN:  if (scan_cnt == (X_W + 1)'(IMG_HDISP + 1)) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // frame start wins from any state, including an unfinished scan
    if (vsync_rise) nxt = ACCUM;
  end

  assign scan_entry = (state == ACCUM) && (nxt == SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0; y_cnt <= '0; win_lo <= '0; win_hi <= '0; thr <= '0;
    end else if (vsync_rise) begin
      x_cnt <= '0; y_cnt <= '0;
      win_lo <= row_start; win_hi <= row_end; thr <= thresh;
    end else if (state == ACCUM) begin
      if (href_fall) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else if (per_frame_clken) begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Read-modify-write: read at x_cnt now, write the sum back next cycle.
  // Row 0 ignores the read value so every frame starts from a clean histogram.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend <= 1'b0; wr_addr <= '0; wr_row0 <= 1'b0; wr_inc <= 1'b0;
    end else begin
      wr_pend <= (state == ACCUM) && per_frame_clken;
      wr_addr <= x_cnt;
      wr_row0 <= (y_cnt == '0);
      wr_inc  <= in_window & per_img_Bit;
    end
  end

  assign wr_data = wr_row0 ? CNT_W'(wr_inc) : rd_data + CNT_W'(wr_inc);
  assign rd_addr = (state == SCAN) ? scan_cnt[X_W-1:0] : x_cnt;

  vip_proj_ram #(.DEPTH(IMG_HDISP), .AW(X_W), .DW(CNT_W)) u_ram (
    .clk(clk), .we(wr_pend), .waddr(wr_addr), .wdata(wr_data),
    .raddr(rd_addr), .rd_data(rd_data)
  );

  // Scan pipeline: address -> RAM data (v1) -> registered ink flag (v2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0; v1 <= 1'b0; v2 <= 1'b0; col1 <= '0; col2 <= '0; ink <= 1'b0;
    end else begin
      if (scan_entry)          scan_cnt <= '0;
      else if (state == SCAN)  scan_cnt <= scan_cnt + 1'b1;
      v1   <= (state == SCAN) && (scan_cnt < (X_W + 1)'(IMG_HDISP));
      col1 <= scan_cnt[X_W-1:0];
      v2   <= v1;
      col2 <= col1;
      ink  <= rd_data > thr;
    end
  end

  always_comb begin
    close_run = 1'b0;
    cl_left   = run_left;
    cl_right  = run_right;
    if (state == SCAN && v2) begin
      if (ink) begin
        if (col2 == X_W'(IMG_HDISP - 1)) begin
          close_run = 1'b1;
          cl_left   = run_open ? run_left : col2;
          cl_right  = col2;
        end
      end else if (run_open) begin
        close_run = 1'b1;
      end
    end
    cl_width = {1'b0, cl_right} - {1'b0, cl_left} + 1'b1;
    keep_run = close_run && (cl_width >= MIN_WV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_open <= 1'b0; run_left <= '0; run_right <= '0;
      sh_left <= '0; sh_right <= '0; sh_num <= '0; sh_ovf <= 1'b0;
    end else if (scan_entry) begin
      run_open <= 1'b0;
      sh_left <= '0; sh_right <= '0; sh_num <= '0; sh_ovf <= 1'b0;
    end else if (state == SCAN && v2) begin
      if (ink && !run_open) begin
        run_open <= 1'b1;
        run_left <= col2;
      end
      if (ink) run_right <= col2;
      if (close_run) run_open <= 1'b0;
      if (keep_run) begin
        if (sh_num < N_W'(MAX_SEG)) begin
          for (int unsigned i = 0; i < MAX_SEG; i++) begin
            if (N_W'(i) == sh_num) begin
              sh_left[i*X_W +: X_W]  <= cl_left;
              sh_right[i*X_W +: X_W] <= cl_right;
            end
          end
          sh_num <= sh_num + 1'b1;
        end else begin
          sh_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_left <= '0; seg_right <= '0; seg_num <= '0; seg_ovf <= 1'b0;
      result_valid <= 1'b0; scan_abort <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      scan_abort   <= vsync_rise && (state == SCAN);
      if (state == DONE) begin
        seg_left  <= sh_left;
        seg_right <= sh_right;
        seg_num   <= sh_num;
        seg_ovf   <= sh_ovf;
      end
    end
  end

endmodule

// File: tb/tb_vip_projection_segmenter.sv
// Directed bench for vip_projection_segmenter on a 16x8 image.
// Two instances share the video: MAX_SEG=8 (dut) and MAX_SEG=2 (dut2).
module tb_vip_projection_segmenter;

  localparam int H = 16;
  localparam int V = 8;

  logic clk = 1'b0;
  logic rst;
  logic vsync, href, clken, bit_in;
  logic [2:0] row_start, row_end;
  logic [3:0] thresh;

  logic p_vsync, p_href, p_clken, p_bit;
  logic [31:0] seg_left, seg_right;
  logic [3:0] seg_num;
  logic seg_ovf, result_valid, scan_abort;

  logic b_vsync, b_href, b_clken, b_bit;
  logic [7:0] b_seg_left, b_seg_right;
  logic [1:0] b_seg_num;
  logic b_seg_ovf, b_result_valid, b_scan_abort;

  vip_projection_segmenter #(.IMG_HDISP(H), .IMG_VDISP(V), .MAX_SEG(8), .MIN_W(2)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(bit_in),
    .post_frame_vsync(p_vsync), .post_frame_href(p_href), .post_frame_clken(p_clken), .post_img_Bit(p_bit),
    .row_start(row_start), .row_end(row_end), .thresh(thresh),
    .seg_left(seg_left), .seg_right(seg_right), .seg_num(seg_num), .seg_ovf(seg_ovf),
    .result_valid(result_valid), .scan_abort(scan_abort)
  );

  vip_projection_segmenter #(.IMG_HDISP(H), .IMG_VDISP(V), .MAX_SEG(2), .MIN_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(bit_in),
    .post_frame_vsync(b_vsync), .post_frame_href(b_href), .post_frame_clken(b_clken), .post_img_Bit(b_bit),
    .row_start(row_start), .row_end(row_end), .thresh(thresh),
    .seg_left(b_seg_left), .seg_right(b_seg_right), .seg_num(b_seg_num), .seg_ovf(b_seg_ovf),
    .result_valid(b_result_valid), .scan_abort(b_scan_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int rv_cnt, rv2_cnt, ab_cnt, tick_no, first_rv;
  logic vid_chk_en = 1'b0;
  logic [3:0] hist0, hist1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // 2-cycle reference delay line for the pass-through video
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist0 <= '0; hist1 <= '0;
    end else begin
      hist0 <= {vsync, href, clken, bit_in};
      hist1 <= hist0;
    end
  end

  always @(negedge clk) begin
    if (vid_chk_en) begin
      check("video_delay", 32'({p_vsync, p_href, p_clken, p_bit}), 32'(hist1));
      check("video_delay2", 32'({b_vsync, b_href, b_clken, b_bit}), 32'(hist1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (result_valid) begin
      rv_cnt++;
      if (first_rv == 0) first_rv = tick_no;
    end
    if (b_result_valid) rv2_cnt++;
    if (scan_abort) ab_cnt++;
  endtask

  task automatic clear_counts();
    rv_cnt = 0; rv2_cnt = 0; ab_cnt = 0; tick_no = 0; first_rv = 0;
  endtask

  task automatic send_frame(input logic [15:0] pat, input logic [2:0] rs, input logic [2:0] re,
                            input logic [3:0] th);
    row_start = rs; row_end = re; thresh = th;
    vsync = 1'b0; tick();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick(); tick();
    for (int r = 0; r < V; r++) begin
      href = 1'b1; clken = 1'b1;
      for (int c = 0; c < H; c++) begin
        bit_in = pat[c];
        tick();
      end
      href = 1'b0; clken = 1'b0; bit_in = 1'b0;
      tick(); tick(); tick();
    end
  endtask

  // Full frame followed by a bounded 40-cycle wait for the result pulse.
  task automatic run_frame(input logic [15:0] pat, input logic [2:0] rs, input logic [2:0] re,
                           input logic [3:0] th);
    clear_counts();
    send_frame(pat, rs, re, th);
    tick_no = 0;
    first_rv = 0;
    repeat (40) tick();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] l, input logic [31:0] r,
                            input logic [3:0] n, input logic ovf);
    check({tag, ".left"}, seg_left, l);
    check({tag, ".right"}, seg_right, r);
    check({tag, ".num"}, 32'(seg_num), 32'(n));
    check({tag, ".ovf"}, 32'(seg_ovf), 32'(ovf));
  endtask

  task automatic expect_out2(input string tag, input logic [7:0] l, input logic [7:0] r,
                             input logic [1:0] n, input logic ovf);
    check({tag, ".b_left"}, 32'(b_seg_left), 32'(l));
    check({tag, ".b_right"}, 32'(b_seg_right), 32'(r));
    check({tag, ".b_num"}, 32'(b_seg_num), 32'(n));
    check({tag, ".b_ovf"}, 32'(b_seg_ovf), 32'(ovf));
  endtask

  task automatic expect_pulses(input string tag);
    check({tag, ".valid_pulses"}, rv_cnt, 1);
    check({tag, ".valid_pulses2"}, rv2_cnt, 1);
    check({tag, ".abort_pulses"}, ab_cnt, 0);
    // last pixel tick + 3 blank ticks, then H+3 cycles from scan entry
    check({tag, ".valid_latency"}, first_rv, 17);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".left"}, seg_left, 32'h0);
    check({tag, ".right"}, seg_right, 32'h0);
    check({tag, ".num_ovf"}, 32'({seg_num, seg_ovf}), 32'h0);
    check({tag, ".pulses"}, 32'({result_valid, scan_abort}), 32'h0);
    check({tag, ".post"}, 32'({p_vsync, p_href, p_clken, p_bit}), 32'h0);
    check({tag, ".b_out"}, 32'({b_seg_left, b_seg_right, b_seg_num, b_seg_ovf}), 32'h0);
  endtask

  localparam logic [15:0] PAT_A = 16'h1E38;  // cols 3-5, 9-12
  localparam logic [15:0] PAT_B = 16'hE080;  // col 7, cols 13-15
  localparam logic [15:0] PAT_C = 16'h4CE6;  // cols 1-2, 5-7, 10-11, 14

  initial begin
    rst = 1'b1;
    vsync = 1'b0; href = 1'b0; clken = 1'b0; bit_in = 1'b0;
    row_start = '0; row_end = '0; thresh = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    run_frame(PAT_A, 3'd0, 3'd7, 4'd2);
    expect_out("two_seg", 32'h93, 32'hC5, 4'd2, 1'b0);
    expect_out2("two_seg", 8'h93, 8'hC5, 2'd2, 1'b0);
    expect_pulses("two_seg");

    run_frame(PAT_A, 3'd6, 3'd7, 4'd2);
    expect_out("win_6_7", 32'h0, 32'h0, 4'd0, 1'b0);
    expect_pulses("win_6_7");

    run_frame(PAT_A, 3'd0, 3'd7, 4'd2);
    expect_out("self_clear", 32'h93, 32'hC5, 4'd2, 1'b0);

    run_frame(PAT_B, 3'd0, 3'd7, 4'd2);
    expect_out("min_w_edge", 32'hD, 32'hF, 4'd1, 1'b0);
    expect_out2("min_w_edge", 8'h0D, 8'h0F, 2'd1, 1'b0);

    run_frame(PAT_C, 3'd0, 3'd7, 4'd2);
    expect_out("three_seg", 32'hA51, 32'hB72, 4'd3, 1'b0);
    expect_out2("three_seg", 8'h51, 8'h72, 2'd2, 1'b1);
    expect_pulses("three_seg");

    // new frame start while the scan of PAT_A is in progress
    clear_counts();
    send_frame(PAT_A, 3'd0, 3'd7, 4'd2);
    repeat (5) tick();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0;
    repeat (30) tick();
    check("abort.abort_pulses", ab_cnt, 1);
    check("abort.valid_pulses", rv_cnt, 0);
    expect_out("abort_hold", 32'hA51, 32'hB72, 4'd3, 1'b0);
    expect_out2("abort_hold", 8'h51, 8'h72, 2'd2, 1'b1);

    run_frame(PAT_A, 3'd0, 3'd7, 4'd2);
    expect_out("after_abort", 32'h93, 32'hC5, 4'd2, 1'b0);
    expect_out2("after_abort", 8'h93, 8'hC5, 2'd2, 1'b0);
    expect_pulses("after_abort");

    run_frame(16'h0000, 3'd0, 3'd7, 4'd0);
    expect_out("empty", 32'h0, 32'h0, 4'd0, 1'b0);
    expect_pulses("empty");

    // three rows in window -> count 3: not ink at thresh 3, ink at thresh 2
    run_frame(PAT_A, 3'd1, 3'd3, 4'd3);
    expect_out("thr_eq", 32'h0, 32'h0, 4'd0, 1'b0);
    run_frame(PAT_A, 3'd1, 3'd3, 4'd2);
    expect_out("thr_below", 32'h93, 32'hC5, 4'd2, 1'b0);

    vid_chk_en = 1'b1;
    repeat (30) begin
      vsync = ($urandom_range(0, 15) == 0);
      href = 1'($urandom_range(0, 1));
      clken = 1'($urandom_range(0, 1));
      bit_in = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick(); tick();
    rst = 1'b0;
    repeat (20) begin
      vsync = ($urandom_range(0, 15) == 0);
      href = 1'($urandom_range(0, 1));
      clken = 1'($urandom_range(0, 1));
      bit_in = 1'($urandom_range(0, 1));
      tick();
    end
    vid_chk_en = 1'b0;
    href = 1'b0; clken = 1'b0; bit_in = 1'b0;

    run_frame(PAT_A, 3'd0, 3'd7, 4'd2);
    expect_out("post_reset", 32'h93, 32'hC5, 4'd2, 1'b0);
    expect_pulses("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
